// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decode control fields through the E, M and W registers,
// resolves branch/jump redirect in Execute and counts retired instructions.
module ctrl_pipe #(
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic [1:0]      ResultSrcD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic [2:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic [2:0]      funct3D,
    input  logic            FlushE,
    input  logic            ZeroE,
    input  logic            LtE,
    input  logic            LtuE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic            ResultSrcE0,
    output logic            RegWriteE,
    output logic            PCSrcE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [CNTW-1:0] InstretCount
);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
        logic [2:0] funct3;
    } ex_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
    } wb_t;

    ex_t            e_q;
    mem_t           m_q;
    wb_t            w_q;
    logic [CNTW-1:0] cnt_q;
    logic           taken;

    // A bubble is all-zero, so downstream write enables are inherently off.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            if (FlushE || !ValidD) begin
                e_q <= '0;
            end else begin
                e_q <= '{valid:       1'b1,
                         reg_write:   RegWriteD,
                         result_src:  ResultSrcD,
                         mem_write:   MemWriteD,
                         jump:        JumpD,
                         branch:      BranchD,
                         alu_control: ALUControlD,
                         alu_src:     ALUSrcD,
                         funct3:      funct3D};
            end
            m_q <= '{valid:      e_q.valid,
                     reg_write:  e_q.reg_write,
                     result_src: e_q.result_src,
                     mem_write:  e_q.mem_write};
            w_q <= '{valid:      m_q.valid,
                     reg_write:  m_q.reg_write,
                     result_src: m_q.result_src};
            if (w_q.valid) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        taken = 1'b0;
        case (e_q.funct3)
            3'b000:  taken = ZeroE;
            3'b001:  taken = !ZeroE;
            3'b100:  taken = LtE;
            3'b101:  taken = !LtE;
            3'b110:  taken = LtuE;
            3'b111:  taken = !LtuE;
            default: taken = 1'b0;
        endcase
    end

    assign PCSrcE       = e_q.valid & (e_q.jump | (e_q.branch & taken));
    assign ALUControlE  = e_q.alu_control;
    assign ALUSrcE      = e_q.alu_src;
    assign ResultSrcE0  = e_q.result_src[0];
    assign RegWriteE    = e_q.reg_write;
    assign RegWriteM    = m_q.reg_write;
    assign MemWriteM    = m_q.mem_write;
    assign ResultSrcM   = m_q.result_src;
    assign RegWriteW    = w_q.reg_write;
    assign ResultSrcW   = w_q.result_src;
    assign InstretCount = cnt_q;

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries decode-stage control fields through the Execute, Memory and Writeback pipeline registers of the 5-stage RISC-V core. It is the consumer end of the decode controller's outputs. It resolves branch/jump redirection in Execute (PCSrcE), supports Execute-stage flush for hazards, and counts retired instructions. It sits between the controller and the datapath/hazard unit.

## Interface
Parameters:
- CNTW, default 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- ValidD  in  1  Decode holds a real instruction (0 = bubble)
- RegWriteD  in  1  register-file write enable
- ResultSrcD  in  2  writeback mux select (00 ALU, 01 mem, 10 PC+4)
- MemWriteD  in  1  data-memory write enable
- JumpD  in  1  jal/jalr
- BranchD  in  1  conditional branch
- ALUControlD  in  3  ALU operation
- ALUSrcD  in  1  ALU B operand select
- funct3D  in  3  branch condition selector
- FlushE  in  1  replace the next Execute contents with a bubble (from the hazard unit)
- ZeroE, LtE, LtuE  in  1 each  ALU flags for the instruction in Execute: equal, signed less-than, unsigned less-than
- ALUControlE  out  3; ALUSrcE  out  1; ResultSrcE0  out  1 (ResultSrcE[0], used for load-use detection); RegWriteE  out  1
- PCSrcE  out  1  redirect fetch to the branch/jump target
- RegWriteM  out  1; MemWriteM  out  1; ResultSrcM  out  2
- RegWriteW  out  1; ResultSrcW  out  2
- InstretCount  out  CNTW  number of retired instructions

## Operation
- Three register stages: D→E, E→M, M→W. Each stage holds a valid bit plus the control fields that are still needed.
- E stage holds: Valid, RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc, funct3.
- M stage holds: Valid, RegWrite, ResultSrc, MemWrite.
- W stage holds: Valid, RegWrite, ResultSrc.
- Bubble encoding: every field is 0. When loading E, if ValidD=0 the D→E register stores a bubble regardless of the other D inputs.
- FlushE=1: the E register loads a bubble on the next edge. The M and W registers advance normally.
- No stall input; M and W advance every cycle.
- Branch taken, by funct3E:
  - 000: ZeroE
  - 001: !ZeroE
  - 100: LtE
  - 101: !LtE
  - 110: LtuE
  - 111: !LtuE
  - 010 and 011: never taken
- PCSrcE = ValidE & (JumpE | (BranchE & taken)). Combinational from the E register and the flags.
- Output gating: all E/M/W control outputs are the registered fields, already zero for bubbles. A bubble can therefore never write the register file or memory.
- InstretCount increments by 1 on each edge where ValidW=1. It wraps from 2^CNTW−1 to 0.

## Timing
- Reset (synchronous): on any edge with reset=1, all stage registers and InstretCount clear to 0. All outputs are then 0, including PCSrcE.
- Reset dominates FlushE and ValidD.
- Latency: an instruction presented in D at edge n appears in E after edge n, in M after n+1 and in W after n+2. It is counted at edge n+3.
- PCSrcE is valid in the same cycle the instruction is in E, with zero added register latency. It is not registered.
- Back-to-back: one instruction per cycle sustained, with no dead cycles.
- FlushE together with ValidD=1: the D instruction is discarded from E. The instruction leaving E still advances to M.
- Reset asserted mid-stream: every in-flight instruction is dropped, with no count or write. The pipeline refills starting at the first edge after reset deasserts.

## Test plan
- Reset: drive all inputs 1 and hold reset for 2 cycles.
  - Required: every output is 0 and InstretCount=0.
- Load flow: ValidD=1, RegWriteD=1, ResultSrcD=01 for one cycle.
  - Required: RegWriteE/M/W=1 in successive cycles, ResultSrcW=01, ResultSrcE0=1 in the E cycle, and InstretCount goes 0→1 three edges after E.
- Branch matrix: BranchD=1 with each funct3 value, sweeping ZeroE/LtE/LtuE.
  - Required: e.g. funct3=101 with LtE=0 gives PCSrcE=1; funct3=010 always gives 0; JumpD=1 gives PCSrcE=1 regardless of the flags.
- Flush: a branch in D with FlushE=1.
  - Required: ValidE=0 and PCSrcE=0 next cycle. The prior E store proceeds with MemWriteM=1. InstretCount increases by only 1.
- Bubble: ValidD=0 with RegWriteD=MemWriteD=JumpD=1.
  - Required: no writes and no PCSrcE downstream, and no count.
- Wrap: CNTW=4 with 17 valid instructions streamed.
  - Required: InstretCount reads 1 after the last retire (15→0→1). Asserting reset mid-stream clears the count to 0 and no M/W writes occur for the dropped instructions.
